// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// bit-period arithmetic. The transmitter uses the same helpers.
package uart_rx_core_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_ARM    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5,
      ST_BREAK  = 3'd6
   } rx_state_e;

   // Clock cycles per bit, rounded to the nearest integer.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core_bit_timer.sv
// uart_bit_timer: loadable down-counter. After a load of N, tick is high
// for one cycle, N cycles later. The counter then rests at zero (busy=0)
// until the next load. A load in the same cycle as tick takes priority.
import uart_rx_core_pkg::*;

module uart_bit_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick,
   output logic         busy
);

   logic [W-1:0] cnt;

   // Count down toward zero; reload on request.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign tick = (cnt == W'(1));
   assign busy = (cnt != '0);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with valid/ready output, sticky framing
// and overrun flags. Define UART_RX_PARITY_EN for 8E1 framing with an
// extra sticky rx_parity_err flag.
import uart_rx_core_pkg::*;

module uart_rx_core #(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int BAUD        = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
   output logic       rx_parity_err,
`endif
   input  logic       err_clr
);

   localparam int              CPB  = clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int              CW   = $clog2(CPB) + 1;
   localparam logic [CW-1:0]   FULL = CW'(CPB);
   localparam logic [CW-1:0]   HALF = CW'(CPB / 2);

   rx_state_e      state;
   logic           rxd_meta, rxd_s, rxd_q;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           tmr_load, tmr_tick, tmr_busy;
   logic [CW-1:0]  tmr_val;
   logic           fall;
`ifdef UART_RX_PARITY_EN
   logic           par_bad;
`endif

   // Two-flop synchronizer plus one delayed copy for edge detection;
   // held at the idle level during reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_q    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
         rxd_q    <= rxd_s;
      end
   end

   assign fall = rxd_q & ~rxd_s;

   // Timer control: ARM restarts the qualification window whenever the
   // line is low; a start edge arms a half-bit wait; every sampled bit
   // rearms a full bit period.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = FULL;
      case (state)
         ST_ARM:   tmr_load = ~rxd_s | ~tmr_busy;
         ST_IDLE:  begin
            tmr_load = fall;
            tmr_val  = HALF;
         end
         ST_START, ST_DATA, ST_PARITY: tmr_load = tmr_tick;
         default:  tmr_load = 1'b0;
      endcase
   end

   uart_bit_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (tmr_tick),
      .busy     (tmr_busy)
   );

   // Receive FSM with registered outputs. Clears and handshake come
   // first so that an error set or a delivery in the same cycle wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_ARM;
         bit_idx      <= '0;
         shreg        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
         par_bad       <= 1'b0;
`endif
      end else begin
         if (err_clr) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
         end
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            ST_ARM:
               if (tmr_tick && rxd_s) state <= ST_IDLE;
            ST_IDLE:
               if (fall) state <= ST_START;
            ST_START:
               if (tmr_tick) begin
                  if (rxd_s) state <= ST_IDLE;
                  else begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                  end
               end
            ST_DATA:
               if (tmr_tick) begin
                  shreg <= {rxd_s, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
`ifdef UART_RX_PARITY_EN
            ST_PARITY:
               if (tmr_tick) begin
                  par_bad <= (rxd_s != ^shreg);
                  if (rxd_s != ^shreg) rx_parity_err <= 1'b1;
                  state <= ST_STOP;
               end
`endif
            ST_STOP:
               if (tmr_tick) begin
                  if (!rxd_s) begin
                     rx_frame_err <= 1'b1;
                     state        <= ST_BREAK;
                  end else begin
                     state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (!par_bad) begin
`else
                     begin
`endif
                        if (!rx_valid || rx_ready) begin
                           rx_data  <= shreg;
                           rx_valid <= 1'b1;
                        end else begin
                           rx_overrun <= 1'b1;
                        end
                     end
                  end
               end
            ST_BREAK:
               if (rxd_s) state <= ST_IDLE;
            default:
               state <= ST_ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at CLKS_PER_BIT=10. Frames are
// built bit by bit from the line format; expected bytes come from what
// was sent. Build with UART_RX_PARITY_EN to cover the 8E1 variant.
module tb_uart_rx_core;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       reset, rxd, rx_ready, err_clr;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err, rx_overrun;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
`endif

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rise_cyc = 0;
   int         rises = 0;
   int         t_start = 0;
   logic       valid_q = 1'b0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   uart_rx_core #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
      .clk          (clk),
      .reset        (reset),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
      .rx_parity_err(rx_parity_err),
`endif
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every handshake and every rising edge of rx_valid.
   always @(negedge clk) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid && !valid_q) begin
         rise_cyc <= cyc;
         rises    <= rises + 1;
      end
      valid_q <= rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_q(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      if (got.size() == exp_q.size())
         foreach (exp_q[i]) check({tag, "_byte"}, got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame. Optionally pulse rx_ready / err_clr for exactly the
   // cycle that ends on the stop-bit sample edge: 2 synchronizer cycles,
   // 1 edge-detect cycle, a half bit, then one bit period per bit before
   // the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input logic rdy_pulse, input logic clr_pulse);
      logic [10:0] frame;
      int nb, lat;
      frame = '1;
      frame[0] = 1'b0;
      frame[8:1] = d;
`ifdef UART_RX_PARITY_EN
      frame[9]  = (^d) ^ par_flip;
      frame[10] = stop;
      nb = 11;
`else
      frame[9] = stop;
      nb = 10;
`endif
      lat = 3 + CPB / 2 + (nb - 1) * CPB;
      @(posedge clk);
      #1;
      t_start = cyc;
      for (int i = 0; i < nb * CPB; i++) begin
         rxd = frame[i / CPB];
         if (rdy_pulse) rx_ready = (i == lat - 1);
         if (clr_pulse) err_clr  = (i == lat - 1);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [7:0] d;
      reset = 1'b1; rxd = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_frame_err", rx_frame_err, 1'b0);
      check("reset_overrun", rx_overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
      check("reset_parity_err", rx_parity_err, 1'b0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;

      // Line stuck low out of reset: nothing may be received.
      repeat (200) @(posedge clk);
      #1;
      check("stuck_low_no_valid", rises, 0);
      check("stuck_low_no_frame_err", rx_frame_err, 1'b0);

      // First byte after the line qualifies as idle.
      idle(20);
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'hA5);
      idle(5);
      check("a5_single_pulse", rises, 1);
      check("a5_latency_ok", (rise_cyc - t_start >= 94) && (rise_cyc - t_start <= 100), 1'b1);
      check_q("a5");

      // 3-cycle glitch is rejected silently, next frame still good.
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(20);
      check("glitch_no_frame_err", rx_frame_err, 1'b0);
      check("glitch_no_overrun", rx_overrun, 1'b0);
      check_q("glitch");
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h3C);
      idle(3);
      check_q("after_glitch");

      // Random bytes with random idle gaps.
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(d);
         idle($urandom_range(1, 4));
      end
      idle(3);
      check_q("random");

      // Framing error: byte dropped, flag sticky until err_clr.
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(20);
      check("stop0_frame_err", rx_frame_err, 1'b1);
      check("stop0_valid", rx_valid, 1'b0);
      check_q("stop0");
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("err_clr_frame", rx_frame_err, 1'b0);
      // err_clr in the same cycle as the error: the set wins.
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      check("clr_vs_set_frame", rx_frame_err, 1'b1);
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      idle(5);
      send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h96);
      idle(3);
      check_q("after_break");

      // Overrun: second byte dropped while the first is unaccepted.
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_valid", rx_valid, 1'b1);
      check("ovr_flag", rx_overrun, 1'b1);
      check_q("ovr_none_taken");
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("err_clr_overrun", rx_overrun, 1'b0);
      // Accept exactly on the delivery cycle: new byte replaces old.
      send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("same_cycle_data", rx_data, 8'h33);
      check("same_cycle_valid", rx_valid, 1'b1);
      check("same_cycle_no_overrun", rx_overrun, 1'b0);
      rx_ready = 1'b1; @(posedge clk); #1; rx_ready = 1'b0;
      @(negedge clk);
      check("drain_valid", rx_valid, 1'b0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h33);
      check_q("same_cycle");

`ifdef UART_RX_PARITY_EN
      rx_ready = 1'b1;
      idle(5);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(5);
      check("parity_err_set", rx_parity_err, 1'b1);
      check("parity_no_frame_err", rx_frame_err, 1'b0);
      check_q("parity_bad");
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("err_clr_parity", rx_parity_err, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h07);
      idle(5);
      check("parity_ok_no_err", rx_parity_err, 1'b0);
      check_q("parity_good");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
